// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Arbitrates two requesters onto one external, combinational ALU and returns
//   the result on a single response channel. Each request is accepted in
//   IDLE, its operands are latched and driven to the ALU during EXEC and RESP,
//   the ALU result is captured in EXEC, and it is presented in RESP until the
//   consumer takes it. This block does no arithmetic of its own.
//
//   Optional feature macro: ALU_SHARE_RR_EN
//     defined   -> round-robin arbitration between req0 and req1
//     undefined -> fixed priority, req0 always wins when valid
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_rs1, reqN_op2       operand A / operand B
//   reqN_aluop               ALU opcode
//   alu_rs1, alu_rs2         operands driven to the shared ALU
//   alu_immi, alu_imms       immediate operands to the ALU (always 0 here)
//   alu_aluop, alu_irmux     opcode and operand select to the ALU
//   alu_result, alu_bt       combinational ALU outputs
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   id of the requester that issued the operation
//   rsp_result, rsp_bt       captured ALU result / branch-taken flag
//   busy                     high whenever the controller is not IDLE
module alu_share_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic [3:0]      req0_aluop,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_op2,
  input  logic [3:0]      req1_aluop,

  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [XLEN-1:0] alu_immi,
  output logic [XLEN-1:0] alu_imms,
  output logic [3:0]      alu_aluop,
  output logic [1:0]      alu_irmux,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_bt,

  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_bt,

  output logic            busy
);

`ifdef ALU_SHARE_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   rs1_q, op2_q;
  logic [3:0]        aluop_q;
  logic              last_grant;

  logic              pick1;
  logic              xfer;
  logic              win_id;
  logic [XLEN-1:0]   win_rs1, win_op2;
  logic [3:0]        win_aluop;

  // Requester 1 wins if it is the only one valid, or, in round-robin mode, if
  // both are valid and requester 0 was granted last. With RR_EN = 0 the
  // last_grant term drops out, leaving fixed priority for requester 0.
  assign pick1 = req1_valid & (~req0_valid | (RR_EN & ~last_grant));

  assign win_id    = pick1;
  assign win_rs1   = pick1 ? req1_rs1   : req0_rs1;
  assign win_op2   = pick1 ? req1_op2   : req0_op2;
  assign win_aluop = pick1 ? req1_aluop : req0_aluop;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xfer       = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = req0_valid & ~pick1;
        req1_ready = pick1;
        xfer       = req0_valid | req1_valid;
        if (xfer) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_rs1   = '0;
    alu_rs2   = '0;
    alu_immi  = '0;
    alu_imms  = '0;
    alu_irmux = 2'b00;
    alu_aluop = ALU_NOP;
    if (state != IDLE) begin
      alu_rs1   = rs1_q;
      alu_rs2   = op2_q;
      alu_aluop = aluop_q;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rs1_q      <= '0;
      op2_q      <= '0;
      aluop_q    <= ALU_NOP;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= '0;
      rsp_bt     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        rs1_q      <= win_rs1;
        op2_q      <= win_op2;
        aluop_q    <= win_aluop;
        rsp_id     <= win_id;
        last_grant <= win_id;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_bt     <= alu_bt;
      end
    end
  end

endmodule
